// File: rtl/symbol_slicer_rx.sv
// symbol_slicer_rx: integrate-and-dump slicer turning noisy oversampled symbols into LSB-first bytes
module symbol_slicer_rx #(
    parameter int SPB    = 4,
    parameter int THRESH = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] sample_in,
    input  logic       sample_valid,
    input  logic       sample_sof,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       overrun,
    output logic       frame_err
);
    localparam int ACC_W = 9 + $clog2(SPB);
    localparam int CNT_W = (SPB > 1) ? $clog2(SPB) : 1;
    localparam logic [ACC_W-1:0] LIM  = ACC_W'(THRESH * SPB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPB - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_bits;
    logic             r_done;
    logic [7:0]       r_byte;
    logic             r_ferr;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_ovr;

    logic             w_take;
    logic             w_restart;
    logic [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt;
    logic [2:0]       w_idx;
    logic [7:0]       w_bits;
    logic             w_bit_end;
    logic             w_bit;
    logic [7:0]       w_new_bits;
    logic             w_last_bit;

    // A sof sample always restarts the frame, so the running state is replaced by zeros before adding it
    always_comb begin
        w_take     = sample_valid & (r_state == COLLECT | sample_sof);
        w_restart  = sample_valid & sample_sof;
        w_sum      = (w_restart ? '0 : r_acc) + ACC_W'(sample_in);
        w_cnt      = w_restart ? '0 : r_cnt;
        w_idx      = w_restart ? '0 : r_bit_idx;
        w_bits     = w_restart ? '0 : r_bits;
        w_bit_end  = w_cnt == LAST;
        w_bit      = w_sum >= LIM;
        w_new_bits = {w_bit, w_bits[7:1]};
        w_last_bit = w_bit_end & (w_idx == 3'd7);
    end

    // Collection FSM: accumulate samples, slice each bit, hand a finished byte to the output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_bits    <= '0;
            r_done    <= 1'b0;
            r_byte    <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= w_restart & (r_state == COLLECT);
            if (w_take) begin
                r_cnt     <= w_bit_end ? '0 : w_cnt + 1'b1;
                r_acc     <= w_bit_end ? '0 : w_sum;
                r_bits    <= w_bit_end ? w_new_bits : w_bits;
                r_bit_idx <= w_bit_end ? w_idx + 3'd1 : w_idx;
                r_state   <= w_last_bit ? IDLE : COLLECT;
                if (w_last_bit) begin
                    r_done <= 1'b1;
                    r_byte <= w_new_bits;
                end
            end
        end
    end

    // Output holding register: load a finished byte if the slot is free or draining, else drop it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (r_done & r_valid & ~data_ready) begin
                r_ovr <= 1'b1;
            end else if (r_done) begin
                r_data  <= r_byte;
                r_valid <= 1'b1;
            end else if (data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign overrun    = r_ovr;
    assign frame_err  = r_ferr;
endmodule
